// File: rtl/adc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// adc_capture_ctrl
//
// Captures a triggered record of packed ADC words (four 14-bit lanes in each
// 64-bit word) and streams it out over a valid/ready interface through a
// small output FIFO. Software arms the block. The record then starts on a
// software trigger, or on a threshold trigger when any lane reaches the
// programmed level.
//
// Ports
//   i_62clk       system clock, rising edge
//   i_nreset      asynchronous active-low reset
//   i_data        packed word, lanes at [13:0],[29:16],[45:32],[61:48]
//   i_data_valid  one-cycle strobe per packed word
//   i_arm         latch config and start acquisition (IDLE/DONE only)
//   i_abort       stop, flush FIFO, return to IDLE (any state)
//   i_sw_trig     software trigger (ARMED only)
//   i_thr_en      threshold trigger enable, latched at arm
//   i_thr_level   unsigned threshold, latched at arm
//   i_rec_len     words per record, latched at arm (0 => arm ignored)
//   o_tdata       output word, lane padding bits forced to 0
//   o_tvalid      o_tdata valid
//   i_tready      downstream accept
//   o_tlast       final word of a complete record
//   o_busy        high in ARMED, CAPTURE, DRAIN
//   o_done        high in DONE
//   o_overflow    sticky overflow flag
//   o_word_cnt    words pushed into FIFO in the current record
// ---------------------------------------------------------------------------
module adc_capture_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic             i_62clk,
    input  logic             i_nreset,
    input  logic [63:0]      i_data,
    input  logic             i_data_valid,
    input  logic             i_arm,
    input  logic             i_abort,
    input  logic             i_sw_trig,
    input  logic             i_thr_en,
    input  logic [13:0]      i_thr_level,
    input  logic [LEN_W-1:0] i_rec_len,
    output logic [63:0]      o_tdata,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic             o_tlast,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overflow,
    output logic [LEN_W-1:0] o_word_cnt
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [63:0] LANE_MASK = 64'h3FFF_3FFF_3FFF_3FFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic             thr_en_q;
    logic [13:0]      thr_level_q;
    logic [LEN_W-1:0] rec_len_q;

    logic [63:0]      fifo_data [FIFO_DEPTH];
    logic             fifo_last [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fifo_cnt;

    logic [LEN_W-1:0] word_cnt;
    logic             overflow_q;

    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             thr_hit;
    logic             arm_accept;
    logic             push_req;
    logic             push;
    logic             push_last;
    logic             drop;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign pop        = !fifo_empty && i_tready;

    assign thr_hit = (i_data[13:0]  >= thr_level_q) ||
                     (i_data[29:16] >= thr_level_q) ||
                     (i_data[45:32] >= thr_level_q) ||
                     (i_data[61:48] >= thr_level_q);

    // State register.
    always_ff @(posedge i_62clk or negedge i_nreset) begin
        if (!i_nreset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and datapath controls. Abort overrides everything. A word
    // that would land on a full FIFO with no pop in the same cycle is
    // dropped, and the record is cut short. The final word of a full record
    // carries tlast.
    always_comb begin
        state_nx   = state;
        arm_accept = 1'b0;
        push_req   = 1'b0;
        push       = 1'b0;
        push_last  = 1'b0;
        drop       = 1'b0;
        if (i_abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_arm && (i_rec_len != '0)) begin
                        state_nx   = ST_ARMED;
                        arm_accept = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (i_sw_trig || (i_data_valid && thr_en_q && thr_hit)) begin
                        state_nx = ST_CAPTURE;
                        push_req = i_data_valid;
                    end
                end
                ST_CAPTURE: begin
                    push_req = i_data_valid;
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state_nx = ST_DONE;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
            if (push_req) begin
                if (fifo_full && !pop) begin
                    drop     = 1'b1;
                    state_nx = ST_DRAIN;
                end else begin
                    push = 1'b1;
                    if (word_cnt == (rec_len_q - LEN_W'(1))) begin
                        push_last = 1'b1;
                        state_nx  = ST_DRAIN;
                    end
                end
            end
        end
    end

    // Configuration is sampled only when an arm is accepted.
    always_ff @(posedge i_62clk or negedge i_nreset) begin
        if (!i_nreset) begin
            thr_en_q    <= 1'b0;
            thr_level_q <= '0;
            rec_len_q   <= '0;
        end else if (arm_accept) begin
            thr_en_q    <= i_thr_en;
            thr_level_q <= i_thr_level;
            rec_len_q   <= i_rec_len;
        end
    end

    // FIFO storage. The padding bits are stripped on entry.
    always_ff @(posedge i_62clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= i_data & LANE_MASK;
            fifo_last[wr_ptr] <= push_last;
        end
    end

    // FIFO pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_62clk or negedge i_nreset) begin
        if (!i_nreset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (i_abort) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Record word counter and sticky overflow flag.
    always_ff @(posedge i_62clk or negedge i_nreset) begin
        if (!i_nreset) begin
            word_cnt   <= '0;
            overflow_q <= 1'b0;
        end else if (i_abort || arm_accept) begin
            word_cnt   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                word_cnt <= word_cnt + LEN_W'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // The head entry is gated by valid, so stale storage never shows on
    // o_tdata after a flush or reset.
    assign o_tvalid   = !fifo_empty;
    assign o_tdata    = o_tvalid ? fifo_data[rd_ptr] : '0;
    assign o_tlast    = o_tvalid && fifo_last[rd_ptr];
    assign o_busy     = (state == ST_ARMED) || (state == ST_CAPTURE) || (state == ST_DRAIN);
    assign o_done     = (state == ST_DONE);
    assign o_overflow = overflow_q;
    assign o_word_cnt = word_cnt;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adc_capture_ctrl
//
// Directed bench for adc_capture_ctrl. Each scenario task drives its own
// stimulus and compares the outputs against hand-computed values. A
// negedge monitor records every accepted output beat as {tlast, tdata}.
// ---------------------------------------------------------------------------
module tb_adc_capture_ctrl;

    localparam int FIFO_DEPTH = 8;
    localparam int LEN_W      = 16;

    logic             i_62clk = 1'b0;
    logic             i_nreset;
    logic [63:0]      i_data;
    logic             i_data_valid;
    logic             i_arm;
    logic             i_abort;
    logic             i_sw_trig;
    logic             i_thr_en;
    logic [13:0]      i_thr_level;
    logic [LEN_W-1:0] i_rec_len;
    logic [63:0]      o_tdata;
    logic             o_tvalid;
    logic             i_tready;
    logic             o_tlast;
    logic             o_busy;
    logic             o_done;
    logic             o_overflow;
    logic [LEN_W-1:0] o_word_cnt;

    int checks = 0;
    int errors = 0;

    logic [64:0] outq [$];

    adc_capture_ctrl #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .LEN_W     (LEN_W)
    ) dut (
        .i_62clk     (i_62clk),
        .i_nreset    (i_nreset),
        .i_data      (i_data),
        .i_data_valid(i_data_valid),
        .i_arm       (i_arm),
        .i_abort     (i_abort),
        .i_sw_trig   (i_sw_trig),
        .i_thr_en    (i_thr_en),
        .i_thr_level (i_thr_level),
        .i_rec_len   (i_rec_len),
        .o_tdata     (o_tdata),
        .o_tvalid    (o_tvalid),
        .i_tready    (i_tready),
        .o_tlast     (o_tlast),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_overflow  (o_overflow),
        .o_word_cnt  (o_word_cnt)
    );

    always #5 i_62clk = ~i_62clk;

    // Inputs change 1 ns after the rising edge, so at the falling edge
    // they are the values the next rising edge will see.
    always @(negedge i_62clk) begin
        if (i_nreset && o_tvalid && i_tready) begin
            outq.push_back({o_tlast, o_tdata});
        end
    end

    function automatic logic [63:0] mk_lanes(input logic [13:0] l0, l1, l2, l3);
        return {2'b10, l3, 2'b01, l2, 2'b11, l1, 2'b10, l0};
    endfunction

    function automatic logic [63:0] exp_lanes(input logic [13:0] l0, l1, l2, l3);
        return {2'b00, l3, 2'b00, l2, 2'b00, l1, 2'b00, l0};
    endfunction

    function automatic logic [63:0] mk_word(input int k);
        return mk_lanes(14'(16*k+1), 14'(16*k+2), 14'(16*k+3), 14'(16*k+4));
    endfunction

    function automatic logic [63:0] exp_word(input int k);
        return exp_lanes(14'(16*k+1), 14'(16*k+2), 14'(16*k+3), 14'(16*k+4));
    endfunction

    task automatic step();
        @(posedge i_62clk);
        #1;
    endtask

    task automatic arm(input logic [LEN_W-1:0] len, input logic en, input logic [13:0] lvl);
        i_rec_len   = len;
        i_thr_en    = en;
        i_thr_level = lvl;
        i_arm       = 1'b1;
        step();
        i_arm = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w);
        i_data       = w;
        i_data_valid = 1'b1;
        step();
        i_data_valid = 1'b0;
    endtask

    task automatic sw_trigger();
        i_sw_trig = 1'b1;
        step();
        i_sw_trig = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!o_done && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_done_timeout: o_done=%b expected 1", name, o_done);
        end
    endtask

    task automatic test_reset();
        i_nreset     = 1'b0;
        i_data       = '0;
        i_data_valid = 1'b0;
        i_arm        = 1'b0;
        i_abort      = 1'b0;
        i_sw_trig    = 1'b0;
        i_thr_en     = 1'b0;
        i_thr_level  = '0;
        i_rec_len    = '0;
        i_tready     = 1'b0;
        repeat (3) step();
        checks++;
        if ({o_tvalid, o_tlast, o_busy, o_done, o_overflow} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 00000",
                     {o_tvalid, o_tlast, o_busy, o_done, o_overflow});
        end
        checks++;
        if (o_word_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL reset_word_cnt: got %0d expected 0", o_word_cnt);
        end
        checks++;
        if (o_tdata !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_tdata: got %h expected 0", o_tdata);
        end
        i_nreset = 1'b1;
        step();
    endtask

    task automatic test_sw_record();
        outq.delete();
        i_tready = 1'b1;
        arm(4, 1'b0, 14'h0);
        sw_trigger();
        send_word(mk_word(0));
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== exp_word(0)) begin
            errors++;
            $display("[TB] FAIL sw_latency: got v=%b d=%h expected v=1 d=%h",
                     o_tvalid, o_tdata, exp_word(0));
        end
        for (int k = 1; k < 6; k++) begin
            send_word(mk_word(k));
        end
        wait_done("sw");
        checks++;
        if (o_word_cnt !== 16'd4) begin
            errors++;
            $display("[TB] FAIL sw_word_cnt: got %0d expected 4", o_word_cnt);
        end
        checks++;
        if (outq.size() != 4) begin
            errors++;
            $display("[TB] FAIL sw_count: got %0d beats expected 4", outq.size());
        end
        for (int k = 0; k < 4 && k < outq.size(); k++) begin
            checks++;
            if (outq[k] !== {(k == 3), exp_word(k)}) begin
                errors++;
                $display("[TB] FAIL sw_beat%0d: got %h expected %h", k, outq[k],
                         {(k == 3), exp_word(k)});
            end
        end
    endtask

    task automatic test_threshold();
        logic [63:0] w [4];
        logic [63:0] e3;
        logic [63:0] e4;
        w[0] = mk_lanes(14'h0100, 14'h0101, 14'h0102, 14'h0103);
        w[1] = mk_lanes(14'h0200, 14'h1FFF, 14'h0202, 14'h0203);
        w[2] = mk_lanes(14'h0010, 14'h1FFF, 14'h2000, 14'h0005);
        w[3] = mk_lanes(14'h0011, 14'h0012, 14'h0013, 14'h0014);
        e3   = exp_lanes(14'h0010, 14'h1FFF, 14'h2000, 14'h0005);
        e4   = exp_lanes(14'h0011, 14'h0012, 14'h0013, 14'h0014);
        outq.delete();
        i_tready = 1'b1;
        arm(2, 1'b1, 14'h2000);
        send_word(w[0]);
        send_word(w[1]);
        checks++;
        if (o_tvalid !== 1'b0 || o_word_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL thr_no_early: got v=%b cnt=%0d expected v=0 cnt=0",
                     o_tvalid, o_word_cnt);
        end
        send_word(w[2]);
        send_word(w[3]);
        wait_done("thr");
        checks++;
        if (outq.size() != 2) begin
            errors++;
            $display("[TB] FAIL thr_count: got %0d beats expected 2", outq.size());
        end
        if (outq.size() == 2) begin
            checks++;
            if (outq[0] !== {1'b0, e3} || outq[1] !== {1'b1, e4}) begin
                errors++;
                $display("[TB] FAIL thr_beats: got %h %h expected %h %h",
                         outq[0], outq[1], {1'b0, e3}, {1'b1, e4});
            end
        end
        outq.delete();
        arm(2, 1'b1, 14'h2001);
        for (int k = 0; k < 4; k++) begin
            send_word(w[k]);
        end
        repeat (3) step();
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0 || o_word_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL thr_miss_state: got busy=%b done=%b cnt=%0d expected 1 0 0",
                     o_busy, o_done, o_word_cnt);
        end
        checks++;
        if (outq.size() != 0) begin
            errors++;
            $display("[TB] FAIL thr_miss_out: got %0d beats expected 0", outq.size());
        end
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
    endtask

    task automatic test_overflow();
        outq.delete();
        i_tready = 1'b0;
        arm(16, 1'b0, 14'h0);
        i_sw_trig = 1'b1;
        send_word(mk_word(0));
        i_sw_trig = 1'b0;
        for (int k = 1; k < 9; k++) begin
            send_word(mk_word(k));
            if (k == 7) begin
                checks++;
                if (o_overflow !== 1'b0 || o_word_cnt !== 16'd8) begin
                    errors++;
                    $display("[TB] FAIL ovf_full: got ovf=%b cnt=%0d expected 0 8",
                             o_overflow, o_word_cnt);
                end
            end
        end
        checks++;
        if (o_overflow !== 1'b1 || o_word_cnt !== 16'd8 || o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_flag: got ovf=%b cnt=%0d busy=%b expected 1 8 1",
                     o_overflow, o_word_cnt, o_busy);
        end
        i_tready = 1'b1;
        wait_done("ovf");
        checks++;
        if (outq.size() != 8) begin
            errors++;
            $display("[TB] FAIL ovf_count: got %0d beats expected 8", outq.size());
        end
        for (int k = 0; k < 8 && k < outq.size(); k++) begin
            checks++;
            if (outq[k] !== {1'b0, exp_word(k)}) begin
                errors++;
                $display("[TB] FAIL ovf_beat%0d: got %h expected %h", k, outq[k],
                         {1'b0, exp_word(k)});
            end
        end
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sticky: got %b expected 1", o_overflow);
        end
    endtask

    task automatic test_abort();
        i_tready = 1'b0;
        arm(10, 1'b0, 14'h0);
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_arm_clr_ovf: got %b expected 0", o_overflow);
        end
        sw_trigger();
        for (int k = 0; k < 3; k++) begin
            send_word(mk_word(k + 10));
        end
        i_abort      = 1'b1;
        i_data       = mk_word(13);
        i_data_valid = 1'b1;
        step();
        i_abort      = 1'b0;
        i_data_valid = 1'b0;
        checks++;
        if (o_tvalid !== 1'b0 || o_busy !== 1'b0 || o_word_cnt !== '0 || o_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_state: got v=%b busy=%b cnt=%0d done=%b expected 0 0 0 0",
                     o_tvalid, o_busy, o_word_cnt, o_done);
        end
        outq.delete();
        i_tready = 1'b1;
        repeat (4) step();
        checks++;
        if (outq.size() != 0) begin
            errors++;
            $display("[TB] FAIL abort_flush: got %0d beats expected 0", outq.size());
        end
    endtask

    task automatic test_arm_rules();
        outq.delete();
        i_tready = 1'b1;
        arm(0, 1'b0, 14'h0);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL arm_len0: got busy=%b expected 0", o_busy);
        end
        arm(3, 1'b0, 14'h0);
        sw_trigger();
        send_word(mk_word(20));
        arm(7, 1'b0, 14'h0);
        send_word(mk_word(21));
        send_word(mk_word(22));
        wait_done("armign");
        checks++;
        if (o_word_cnt !== 16'd3 || outq.size() != 3) begin
            errors++;
            $display("[TB] FAIL armign_len: got cnt=%0d beats=%0d expected 3 3",
                     o_word_cnt, outq.size());
        end
        for (int k = 0; k < 3 && k < outq.size(); k++) begin
            checks++;
            if (outq[k] !== {(k == 2), exp_word(k + 20)}) begin
                errors++;
                $display("[TB] FAIL armign_beat%0d: got %h expected %h", k, outq[k],
                         {(k == 2), exp_word(k + 20)});
            end
        end
    endtask

    task automatic test_async_reset();
        i_tready = 1'b0;
        arm(4, 1'b0, 14'h0);
        i_sw_trig = 1'b1;
        send_word(mk_word(30));
        i_sw_trig = 1'b0;
        for (int k = 1; k < 4; k++) begin
            send_word(mk_word(30 + k));
        end
        checks++;
        if (o_busy !== 1'b1 || o_tvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ar_drain: got busy=%b v=%b expected 1 1", o_busy, o_tvalid);
        end
        #2;
        i_nreset = 1'b0;
        #1;
        checks++;
        if ({o_tvalid, o_tlast, o_busy, o_done, o_overflow} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL ar_flags: got %b expected 00000",
                     {o_tvalid, o_tlast, o_busy, o_done, o_overflow});
        end
        checks++;
        if (o_word_cnt !== '0 || o_tdata !== 64'h0) begin
            errors++;
            $display("[TB] FAIL ar_data: got cnt=%0d d=%h expected 0 0", o_word_cnt, o_tdata);
        end
        step();
        i_nreset = 1'b1;
        step();
        outq.delete();
        i_tready = 1'b1;
        arm(2, 1'b0, 14'h0);
        sw_trigger();
        send_word(mk_word(40));
        send_word(mk_word(41));
        wait_done("ar_rearm");
        checks++;
        if (outq.size() != 2) begin
            errors++;
            $display("[TB] FAIL ar_rearm_count: got %0d beats expected 2", outq.size());
        end
        if (outq.size() == 2) begin
            checks++;
            if (outq[0] !== {1'b0, exp_word(40)} || outq[1] !== {1'b1, exp_word(41)}) begin
                errors++;
                $display("[TB] FAIL ar_rearm_beats: got %h %h expected %h %h", outq[0],
                         outq[1], {1'b0, exp_word(40)}, {1'b1, exp_word(41)});
            end
        end
    endtask

    initial begin
        $display("[TB] starting adc_capture_ctrl bench");
        test_reset();
        test_sw_record();
        test_threshold();
        test_overflow();
        test_abort();
        test_arm_rules();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
